// File: rtl/lcd_id_pkg.sv
// Shared definitions for panel identification: strap codes, panel IDs,
// per-panel resolutions, the strap decoder and the detector FSM states.
package lcd_id_pkg;

    localparam logic [2:0] CODE_4342 = 3'b000;
    localparam logic [2:0] CODE_7084 = 3'b001;
    localparam logic [2:0] CODE_7016 = 3'b010;
    localparam logic [2:0] CODE_4384 = 3'b100;
    localparam logic [2:0] CODE_1018 = 3'b101;

    localparam logic [15:0] ID_4342 = 16'h4342;
    localparam logic [15:0] ID_7084 = 16'h7084;
    localparam logic [15:0] ID_7016 = 16'h7016;
    localparam logic [15:0] ID_4384 = 16'h4384;
    localparam logic [15:0] ID_1018 = 16'h1018;

    localparam logic [10:0] H_4342 = 11'd480;
    localparam logic [10:0] V_4342 = 11'd272;
    localparam logic [10:0] H_7084 = 11'd800;
    localparam logic [10:0] V_7084 = 11'd480;
    localparam logic [10:0] H_7016 = 11'd1024;
    localparam logic [10:0] V_7016 = 11'd600;
    localparam logic [10:0] H_4384 = 11'd800;
    localparam logic [10:0] V_4384 = 11'd480;
    localparam logic [10:0] H_1018 = 11'd1280;
    localparam logic [10:0] V_1018 = 11'd800;

    typedef struct packed {
        logic [15:0] id;
        logic [10:0] h;
        logic [10:0] v;
        logic        known;
    } panel_info_t;

    typedef enum logic [1:0] {
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    // Unassigned codes come back with known=0; the caller substitutes its defaults.
    function automatic panel_info_t decode_strap(input logic [2:0] code);
        panel_info_t info;
        info = '0;
        unique case (code)
            CODE_4342: info = '{id: ID_4342, h: H_4342, v: V_4342, known: 1'b1};
            CODE_7084: info = '{id: ID_7084, h: H_7084, v: V_7084, known: 1'b1};
            CODE_7016: info = '{id: ID_7016, h: H_7016, v: V_7016, known: 1'b1};
            CODE_4384: info = '{id: ID_4384, h: H_4384, v: V_4384, known: 1'b1};
            CODE_1018: info = '{id: ID_1018, h: H_1018, v: V_1018, known: 1'b1};
            default:   info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/lcd_id_if.sv
// Signal bundle between the panel-ID detector and its environment
// (strap/pixel bus in, decoded panel description out).
interface lcd_id_if;

    logic [23:0] lcd_rgb;
    logic        redetect;
    logic [15:0] lcd_id;
    logic [10:0] h_disp;
    logic [10:0] v_disp;
    logic        id_valid;
    logic        id_default;

    modport master (
        output lcd_rgb, redetect,
        input  lcd_id, h_disp, v_disp, id_valid, id_default
    );

    modport slave (
        input  lcd_rgb, redetect,
        output lcd_id, h_disp, v_disp, id_valid, id_default
    );

endinterface

// File: rtl/strap_sync.sv
// Generic multi-bit, STAGES-deep flop synchroniser with async reset to zero.
module strap_sync #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    // NOTE: sequential state always uses non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/lcd_id_detect.sv
// Panel identification front end: synchronises the mode straps, settles,
// waits for a stable run of samples and registers the decoded panel ID.
module lcd_id_detect
    import lcd_id_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter int          SETTLE_CYC  = 1000,
    parameter int          STABLE_CNT  = 16,
    parameter int          TIMEOUT_CYC = 65536,
    parameter logic [15:0] DEFAULT_ID  = 16'h7084,
    parameter int          DEFAULT_H   = 800,
    parameter int          DEFAULT_V   = 480
) (
    input  logic     clk,
    input  logic     rst_n,
    lcd_id_if.slave  bus
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int RW = $clog2(STABLE_CNT + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]    w_strap_raw;
    logic [2:0]    w_strap;

    state_t        r_state;
    logic [SW-1:0] r_settle_cnt;
    logic [RW-1:0] r_run;
    logic [TW-1:0] r_tmo;
    logic [2:0]    r_ref;
    logic [15:0]   r_lcd_id;
    logic [10:0]   r_h_disp;
    logic [10:0]   r_v_disp;
    logic          r_id_valid;
    logic          r_id_default;

    panel_info_t   w_info;
    logic [RW-1:0] w_run_nxt;
    logic [TW-1:0] w_tmo_nxt;
    logic          w_stable;
    logic          w_timeout;

    // Strap order is {M2, M1, M0} = {B7, G7, R7}.
    assign w_strap_raw = {bus.lcd_rgb[7], bus.lcd_rgb[15], bus.lcd_rgb[23]};

    strap_sync #(
        .WIDTH  (3),
        .STAGES (SYNC_STAGES)
    ) u_strap_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_strap_raw),
        .o_q   (w_strap)
    );

    always_comb begin
        w_info    = decode_strap(r_ref);
        w_run_nxt = (w_strap == r_ref) ? r_run + RW'(1) : RW'(1);
        w_tmo_nxt = r_tmo + TW'(1);
        w_stable  = (w_run_nxt == RW'(STABLE_CNT));
        w_timeout = (w_tmo_nxt == TW'(TIMEOUT_CYC));
    end

    // r_tmo == 0 marks the first SAMPLE edge, which only seeds the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SETTLE;
            r_settle_cnt <= '0;
            r_run        <= '0;
            r_tmo        <= '0;
            r_ref        <= '0;
            r_lcd_id     <= '0;
            r_h_disp     <= '0;
            r_v_disp     <= '0;
            r_id_valid   <= 1'b0;
            r_id_default <= 1'b0;
        end else begin
            unique case (r_state)
                SETTLE: begin
                    if (bus.redetect) begin
                        r_settle_cnt <= '0;
                    end else if (r_settle_cnt == SW'(SETTLE_CYC - 1)) begin
                        r_settle_cnt <= '0;
                        r_state      <= SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SW'(1);
                    end
                end

                SAMPLE: begin
                    if (bus.redetect) begin
                        r_run   <= '0;
                        r_tmo   <= '0;
                        r_state <= SETTLE;
                    end else if (r_tmo == '0) begin
                        r_ref <= w_strap;
                        r_run <= RW'(1);
                        r_tmo <= TW'(1);
                    end else if (w_stable) begin
                        r_lcd_id     <= w_info.known ? w_info.id : DEFAULT_ID;
                        r_h_disp     <= w_info.known ? w_info.h  : 11'(DEFAULT_H);
                        r_v_disp     <= w_info.known ? w_info.v  : 11'(DEFAULT_V);
                        r_id_default <= ~w_info.known;
                        r_id_valid   <= 1'b1;
                        r_state      <= DONE;
                    end else if (w_timeout) begin
                        r_lcd_id     <= DEFAULT_ID;
                        r_h_disp     <= 11'(DEFAULT_H);
                        r_v_disp     <= 11'(DEFAULT_V);
                        r_id_default <= 1'b1;
                        r_id_valid   <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_ref <= w_strap;
                        r_run <= w_run_nxt;
                        r_tmo <= w_tmo_nxt;
                    end
                end

                DONE: begin
                    // The bus now carries pixels; only a redetect request matters.
                    if (bus.redetect) begin
                        r_id_valid   <= 1'b0;
                        r_id_default <= 1'b0;
                        r_settle_cnt <= '0;
                        r_run        <= '0;
                        r_tmo        <= '0;
                        r_state      <= SETTLE;
                    end
                end

                default: r_state <= SETTLE;
            endcase
        end
    end

    assign bus.lcd_id     = r_lcd_id;
    assign bus.h_disp     = r_h_disp;
    assign bus.v_disp     = r_v_disp;
    assign bus.id_valid   = r_id_valid;
    assign bus.id_default = r_id_default;

endmodule

// File: tb/tb_lcd_id_detect.sv
// Scoreboard bench for lcd_id_detect: per-cycle strap schedules, a window-based
// reference model and a monitor that checks each id_valid rise and hold.
module tb_lcd_id_detect;

    localparam int SETTLE  = 8;
    localparam int STABLE  = 4;
    localparam int TIMEOUT = 32;
    localparam int SYNC    = 2;
    localparam int MAXC    = 1024;

    typedef struct {
        logic [15:0] id;
        logic [10:0] h;
        logic [10:0] v;
        logic        dflt;
        int          at_edge;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc;
    int   checks   = 0;
    int   failures = 0;
    int   redet_at = -1;
    logic [2:0] sched [MAXC];
    exp_t exp_q [$];
    exp_t held;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    lcd_id_if bus ();

    lcd_id_detect #(
        .SYNC_STAGES (SYNC),
        .SETTLE_CYC  (SETTLE),
        .STABLE_CNT  (STABLE),
        .TIMEOUT_CYC (TIMEOUT),
        .DEFAULT_ID  (16'h7084),
        .DEFAULT_H   (800),
        .DEFAULT_V   (480)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Edge index since reset release: cyc == k between edge k-1 and edge k.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic exp_t ref_panel(input logic [2:0] code);
        exp_t r;
        case (code)
            3'b000:  r = '{16'h4342, 11'd480,  11'd272, 1'b0, 0};
            3'b001:  r = '{16'h7084, 11'd800,  11'd480, 1'b0, 0};
            3'b010:  r = '{16'h7016, 11'd1024, 11'd600, 1'b0, 0};
            3'b100:  r = '{16'h4384, 11'd800,  11'd480, 1'b0, 0};
            3'b101:  r = '{16'h1018, 11'd1280, 11'd800, 1'b0, 0};
            default: r = '{16'h7084, 11'd800,  11'd480, 1'b1, 0};
        endcase
        return r;
    endfunction

    // Straps presented at edge e reach the decision logic SYNC edges later.
    function automatic logic [2:0] strap_at(input int e);
        if (e < SYNC || e - SYNC >= MAXC) return 3'b000;
        return sched[e - SYNC];
    endfunction

    // Detection started at edge 'start': samples begin SETTLE edges later; accept
    // the first window of STABLE equal samples, else fall back at TIMEOUT samples.
    function automatic exp_t model(input int start);
        logic [2:0] win [$];
        exp_t r;
        for (int j = 0; j < TIMEOUT; j++) begin
            bit same;
            win.push_back(strap_at(start + SETTLE + j));
            if (win.size() > STABLE) void'(win.pop_front());
            same = (win.size() == STABLE);
            foreach (win[k]) if (win[k] != win[0]) same = 1'b0;
            if (same) begin
                r = ref_panel(win[STABLE-1]);
                r.at_edge = start + SETTLE + j;
                return r;
            end
        end
        r = '{16'h7084, 11'd800, 11'd480, 1'b1, start + SETTLE + TIMEOUT - 1};
        return r;
    endfunction

    task automatic drive();
        logic [23:0] px;
        logic [2:0]  s;
        px = 24'($urandom);
        s  = (cyc >= 0 && cyc < MAXC) ? sched[cyc] : 3'b000;
        px[7]  = s[2];
        px[15] = s[1];
        px[23] = s[0];
        bus.lcd_rgb  = px;
        bus.redetect = (cyc == redet_at);
    endtask

    initial begin
        drive();
        forever begin
            @(negedge clk);
            drive();
        end
    end

    // Monitor: pops one expectation per id_valid rise, checks hold while valid.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (bus.id_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", 64'(bus.id_valid), 64'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("lcd_id",     64'(bus.lcd_id),     64'(e.id));
                        check("h_disp",     64'(bus.h_disp),     64'(e.h));
                        check("v_disp",     64'(bus.v_disp),     64'(e.v));
                        check("id_default", 64'(bus.id_default), 64'(e.dflt));
                        check("valid_edge", 64'(cyc - 1),        64'(e.at_edge));
                        held = e;
                    end
                end else if (bus.id_valid && prev_valid) begin
                    check("hold", {25'd0, bus.lcd_id, bus.h_disp, bus.v_disp, bus.id_default},
                          {25'd0, held.id, held.h, held.v, held.dflt});
                end
                prev_valid = bus.id_valid;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        redet_at = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_outputs", {25'd0, bus.lcd_id, bus.h_disp, bus.v_disp, bus.id_default, bus.id_valid}, 64'd0);
    endtask

    task automatic wait_edge(input int e);
        int guard = 0;
        while (cyc <= e && guard < MAXC) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        // Constant 001: valid after edge SETTLE+STABLE-1.
        for (int k = 0; k < MAXC; k++) sched[k] = 3'b001;
        do_reset();
        exp_q.push_back(model(0));
        drain();

        // 101 then 100 from cycle 9: run restarts on the change.
        for (int k = 0; k < MAXC; k++) sched[k] = (k < 9) ? 3'b101 : 3'b100;
        do_reset();
        exp_q.push_back(model(0));
        drain();

        // Toggling every cycle: timeout fallback.
        for (int k = 0; k < MAXC; k++) sched[k] = k[0] ? 3'b111 : 3'b000;
        do_reset();
        exp_q.push_back(model(0));
        drain();

        // Unknown code held: default with id_default.
        for (int k = 0; k < MAXC; k++) sched[k] = 3'b111;
        do_reset();
        exp_q.push_back(model(0));
        drain();

        // Detect 000, straps move to 010, redetect from DONE.
        for (int k = 0; k < MAXC; k++) sched[k] = (k < 15) ? 3'b000 : 3'b010;
        do_reset();
        redet_at = 25;
        exp_q.push_back(model(0));
        exp_q.push_back(model(26));
        wait_edge(25);
        check("redet_valid_low",   64'(bus.id_valid),   64'd0);
        check("redet_default_low", 64'(bus.id_default), 64'd0);
        check("redet_id_kept",     64'(bus.lcd_id),     64'h4342);
        drain();

        // Redetect while sampling restarts the settle period.
        for (int k = 0; k < MAXC; k++) sched[k] = 3'b010;
        do_reset();
        redet_at = 10;
        exp_q.push_back(model(11));
        drain();

        // Async reset during a re-detection SAMPLE phase.
        for (int k = 0; k < MAXC; k++) sched[k] = 3'b101;
        do_reset();
        redet_at = 20;
        exp_q.push_back(model(0));
        wait_edge(30);
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs",
              {25'd0, bus.lcd_id, bus.h_disp, bus.v_disp, bus.id_default, bus.id_valid}, 64'd0);
        do_reset();
        exp_q.push_back(model(0));
        drain();

        // Randomised strap schedules with varying glitch density.
        for (int it = 0; it < 10; it++) begin
            logic [2:0] base;
            int mode;
            base = 3'($urandom_range(0, 7));
            mode = $urandom_range(0, 3);
            for (int k = 0; k < MAXC; k++) begin
                bit glitch;
                case (mode)
                    0:       glitch = 1'b0;
                    1:       glitch = ($urandom_range(0, 7) == 0);
                    2:       glitch = ($urandom_range(0, 1) == 0);
                    default: glitch = 1'b1;
                endcase
                sched[k] = glitch ? 3'($urandom_range(0, 7)) : base;
            end
            do_reset();
            exp_q.push_back(model(0));
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_id_detect.md
Name: lcd_id_detect

Overview:
- Panel-identification front end for the RGB LCD path, and successor to the one-shot strap reader.
- Synchronises the panel's mode straps (M2:B7, M1:G7, M0:R7 on the shared lcd_rgb bus) and waits a settle time.
- Requires a run of identical samples before decoding the panel ID and active resolution.
- Supports timeout fallback, unknown-code fallback and software-requested re-detection (hot-plug); the timing generator and framebuffer readers consume its outputs.

Parameters:
- SYNC_STAGES, 2, flops in the strap synchroniser (>=2).
- SETTLE_CYC, 1000, cycles spent in SETTLE before sampling starts (must be >= SYNC_STAGES).
- STABLE_CNT, 16, consecutive identical samples required to accept a code (>=2).
- TIMEOUT_CYC, 65536, max SAMPLE cycles before falling back (must be > STABLE_CNT).
- DEFAULT_ID, 16'h7084, ID reported on timeout or unknown code.
- DEFAULT_H, 800, h_disp reported with DEFAULT_ID.
- DEFAULT_V, 480, v_disp reported with DEFAULT_ID.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- lcd_rgb  in  24  RGB bus; bits 7/15/23 carry the M2/M1/M0 straps.
- redetect  in  1  single-cycle request to re-run detection.
- lcd_id  out  16  decoded panel ID.
- h_disp  out  11  active pixels per line.
- v_disp  out  11  active lines per frame.
- id_valid  out  1  high while lcd_id/h_disp/v_disp are valid.
- id_default  out  1  high when the result came from the fallback path.

Behaviour:
- Reset: state=SETTLE; all counters 0; lcd_id=0, h_disp=0, v_disp=0, id_valid=0, id_default=0.
- Strap code: s = synchronised {lcd_rgb[7], lcd_rgb[15], lcd_rgb[23]}, passed through the SYNC_STAGES-deep synchroniser.
- Decode table (code -> ID, H x V):
  - 000 -> 4342, 480x272
  - 001 -> 7084, 800x480
  - 010 -> 7016, 1024x600
  - 100 -> 4384, 800x480
  - 101 -> 1018, 1280x800
  - 011/110/111 -> DEFAULT_ID, DEFAULT_H x DEFAULT_V, id_default=1
- Cycle numbering: cycle 0 is the first clk edge with rst_n high.
- SETTLE:
  - Counts SETTLE_CYC edges (cycles 0..SETTLE_CYC-1), then -> SAMPLE.
- SAMPLE:
  - The first edge loads ref=s, run=1, tmo=1.
  - Each later edge increments tmo.
  - If s==ref, run increments; otherwise ref=s and run=1.
  - On the edge where run reaches STABLE_CNT: register decode(ref) outputs, id_valid=1, -> DONE.
  - On the edge where tmo reaches TIMEOUT_CYC without stability: lcd_id=DEFAULT_ID, h/v=DEFAULT_H/V, id_default=1, id_valid=1, -> DONE.
  - If stability and timeout occur on the same edge, stability wins.
- Latency with constant straps: id_valid is high after edge SETTLE_CYC+STABLE_CNT-1.
- DONE:
  - Outputs hold; straps are ignored (the bus is carrying pixel data).
- redetect:
  - In DONE: next edge id_valid=0, id_default=0, counters cleared, -> SETTLE. lcd_id/h_disp/v_disp keep their old values until the new result is registered.
  - In SETTLE/SAMPLE: counters cleared, restart SETTLE.
- Reset asserted mid-operation: all state returns to reset values immediately (async).
- Counter widths: $clog2(param+1); no wrap is possible because counters stop on their terminal condition.

Decomposition:
- Package lcd_id_pkg holds:
  - Strap code constants (CODE_4342 … CODE_1018).
  - Panel ID constants.
  - Per-panel H/V resolution constants.
  - Pure function decode_strap(code) returning {id, h, v, known}.
  - FSM state enum {SETTLE, SAMPLE, DONE}.
- One sub-module: strap_sync, a generic N-bit, SYNC_STAGES-deep synchroniser with async reset to 0.

Test Plan (SETTLE_CYC=8, STABLE_CNT=4, TIMEOUT_CYC=32, SYNC_STAGES=2):
- Straps 001 constant from reset -> id_valid rises after edge 11; lcd_id=7084, h=800, v=480, id_default=0.
- Straps 101, toggled to 100 once at cycle 9 then held at 100 -> run restarts; final lcd_id=4384, 800x480, id_valid after the 4th consecutive 100 sample.
- Straps toggling every cycle -> at SAMPLE edge 32: lcd_id=7084, id_default=1, id_valid=1.
- Straps 111 constant -> lcd_id=DEFAULT_ID=7084, 800x480, id_default=1.
- Detect 000 (4342, 480x272), change straps to 010, pulse redetect -> id_valid low next cycle with lcd_id still 4342; 12 cycles later lcd_id=7016, 1024x600, id_valid=1.
- Assert rst_n low during SAMPLE -> all outputs 0 immediately; after release, detection restarts from cycle 0.
